// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle: instruction memory port, fetch control/redirect inputs,
// and the decode-facing valid/ready instruction stream.
interface imem_fetch_ctrl_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_data, fetch_en, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_addr, inst_valid, inst_data, inst_pc,
        output imem_data, fetch_en, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: holds each PC for WAIT_CYCLES to cover the
// asynchronous memory read, then queues {pc, word} in a 2-entry prefetch FIFO.
module imem_fetch_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          WAIT_CYCLES = 2
) (
    input logic               CLK,
    input logic               Reset,
    imem_fetch_ctrl_if.master bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [63:0]       pc;
    logic [31:0]       hold_data;
    logic [1:0]        count;
    logic [1:0][63:0]  q_pc;
    logic [1:0][31:0]  q_data;

    logic        pop;
    logic        space;
    logic        push;
    logic [31:0] push_data;

    assign bus.imem_addr  = pc;
    assign bus.inst_valid = (count != 2'd0);
    assign bus.inst_pc    = q_pc[0];
    assign bus.inst_data  = q_data[0];

    // A full queue still has room when the head leaves on the same edge.
    always_comb begin
        pop       = (count != 2'd0) && bus.inst_ready;
        space     = (count != 2'd2) || pop;
        push      = 1'b0;
        push_data = bus.imem_data;
        case (state)
            WAIT:    push = (cnt <= 4'd1) && space;
            HOLD: begin
                push      = space;
                push_data = hold_data;
            end
            default: push = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pc        <= RESET_PC;
            hold_data <= '0;
            count     <= 2'd0;
            q_pc      <= '0;
            q_data    <= '0;
        end else if (bus.redirect_valid) begin
            // Flush wins over any push/pop this cycle; restart fetch unconditionally.
            state     <= WAIT;
            cnt       <= WAIT_LD;
            pc        <= {bus.redirect_pc[63:2], 2'b00};
            hold_data <= '0;
            count     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.fetch_en) begin
                        cnt   <= WAIT_LD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt > 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else if (!space) begin
                        hold_data <= bus.imem_data;
                        state     <= HOLD;
                    end else if (!bus.fetch_en) begin
                        state <= IDLE;
                    end else begin
                        cnt <= WAIT_LD;
                    end
                end
                HOLD: begin
                    if (space) begin
                        if (bus.fetch_en) begin
                            cnt   <= WAIT_LD;
                            state <= WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) pc <= pc + 64'd4;

            case ({push, pop})
                2'b10: begin
                    q_pc[count[0]]   <= pc;
                    q_data[count[0]] <= push_data;
                    count            <= count + 2'd1;
                end
                2'b01: begin
                    q_pc[0]   <= q_pc[1];
                    q_data[0] <= q_data[1];
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: new word lands behind whatever survives.
                    if (count == 2'd1) begin
                        q_pc[0]   <= pc;
                        q_data[0] <= push_data;
                    end else begin
                        q_pc[0]   <= q_pc[1];
                        q_data[0] <= q_data[1];
                        q_pc[1]   <= pc;
                        q_data[1] <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: cycle-exact stream, backpressure/HOLD,
// redirects, fetch_en gating and mid-read reset against a small memory table.
module tb_imem_fetch_ctrl;
    logic CLK;
    logic Reset;
    int   checks;
    int   errors;

    imem_fetch_ctrl_if bus();

    imem_fetch_ctrl #(.RESET_PC(64'h0), .WAIT_CYCLES(2)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h00:  return 32'hF84003E9;
            64'h04:  return 32'hF84083EA;
            64'h08:  return 32'hF84103EB;
            64'h0C:  return 32'hF84183EC;
            64'h10:  return 32'hF84203ED;
            64'h14:  return 32'hF84283EE;
            64'h18:  return 32'hF84303EF;
            64'h1C:  return 32'hAA551C1C;
            64'h20:  return 32'h8B0901AD;
            64'h24:  return 32'h8B0A01CE;
            64'h28:  return 32'h8B0B01EF;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr);

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic head(input string tag, input logic [63:0] pc, input logic [31:0] data);
        chk({tag, "_valid"}, {63'd0, bus.inst_valid}, 64'd1);
        chk({tag, "_pc"}, bus.inst_pc, pc);
        chk({tag, "_data"}, {32'd0, bus.inst_data}, {32'd0, data});
    endtask

    task automatic empty(input string tag, input logic [63:0] addr);
        chk({tag, "_valid"}, {63'd0, bus.inst_valid}, 64'd0);
        chk({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        Reset              = 1'b1;
        bus.fetch_en       = 1'b1;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        step;
        step;
        empty("rst", 64'h0);
        chk("rst_pc", bus.inst_pc, 64'h0);
        chk("rst_data", {32'd0, bus.inst_data}, 64'h0);

        // Stream: first valid in cycle 3, then one word every 2 cycles.
        Reset = 1'b0;
        empty("c0", 64'h0);
        step; empty("c1", 64'h0);
        step; empty("c2", 64'h0);
        step; head("c3", 64'h0, 32'hF84003E9);
        step; empty("c4", 64'h8 - 64'h4);
        step; head("c5", 64'h4, 32'hF84083EA);
        step;
        step; head("c7", 64'h8, 32'hF84103EB);
        step;
        step; head("c9", 64'hC, 32'hF84183EC);
        bus.inst_ready = 1'b0;
        step; head("c10", 64'hC, 32'hF84183EC);

        // Reset lands on the sampling edge of the 0x10 read: nothing pushed.
        Reset = 1'b1;
        step; empty("rst_mid", 64'h0);
        chk("rst_mid_pc", bus.inst_pc, 64'h0);
        step; empty("rst_hold", 64'h0);

        // Backpressure for 20 cycles: queue fills, FSM parks in HOLD at 0x8.
        Reset = 1'b0;
        for (int r = 0; r < 20; r++) begin
            if (r < 3) chk("bp_empty", {63'd0, bus.inst_valid}, 64'd0);
            else       head("bp_head", 64'h0, 32'hF84003E9);
            if (r == 19) chk("bp_addr", bus.imem_addr, 64'h8);
            else         step;
        end
        bus.inst_ready = 1'b1;
        step; head("bp_r20", 64'h4, 32'hF84083EA);
        chk("bp_r20_addr", bus.imem_addr, 64'hC);
        step; head("bp_r21", 64'h8, 32'hF84103EB);
        step; head("bp_r22", 64'hC, 32'hF84183EC);
        bus.inst_ready = 1'b0;
        step; head("r23", 64'hC, 32'hF84183EC);
        step; head("r24", 64'hC, 32'hF84183EC);
        chk("r24_addr", bus.imem_addr, 64'h14);

        // Redirect with two queued entries and 0x14 mid-read.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h1C;
        bus.inst_ready     = 1'b1;
        step; empty("rd1_n1", 64'h1C);
        bus.redirect_valid = 1'b0;
        step; empty("rd1_n2", 64'h1C);
        step; head("rd1_n3", 64'h1C, 32'hAA551C1C);
        step; empty("r28", 64'h20);
        step; head("r29", 64'h20, 32'h8B0901AD);
        bus.inst_ready = 1'b0;
        step; head("r30", 64'h20, 32'h8B0901AD);
        step; head("r31", 64'h20, 32'h8B0901AD);
        chk("r31_addr", bus.imem_addr, 64'h28);
        step; head("r32", 64'h20, 32'h8B0901AD);

        // Redirect to misaligned 0x23 coinciding with a pop and a push.
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h23;
        step; empty("rd2_n1", 64'h20);
        bus.redirect_valid = 1'b0;
        step; empty("rd2_n2", 64'h20);
        step; head("rd2_n3", 64'h20, 32'h8B0901AD);

        // fetch_en drops during WAIT: in-flight word still delivered, then idle.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h10;
        step; empty("fe_n1", 64'h10);
        bus.redirect_valid = 1'b0;
        bus.fetch_en       = 1'b0;
        step; empty("fe_n2", 64'h10);
        step; head("fe_n3", 64'h10, 32'hF84203ED);
        chk("fe_n3_addr", bus.imem_addr, 64'h14);
        for (int i = 0; i < 6; i++) begin
            step; empty("fe_idle", 64'h14);
        end
        bus.fetch_en = 1'b1;
        step; empty("fe_re1", 64'h14);
        step; empty("fe_re2", 64'h14);
        step; head("fe_re3", 64'h14, 32'hF84283EE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction fetch sequencer for the read-only instruction memory. It owns the fetch PC and holds each address stable for a fixed number of cycles to cover the memory's asynchronous read delay. It then captures the returned word into a 2-entry prefetch queue that the decode stage drains through a valid/ready handshake. Branch redirects (B, CBZ taken) flush the queue, abort the in-flight read and restart fetch at the new PC.

## Interface
- RESET_PC, 64'h0, PC loaded on reset.
- WAIT_CYCLES, 2, cycles each address is held before the data word is sampled. Legal range is 1..15.

- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- imem_addr  out  64  address driven to instruction memory.
- imem_data  in  32  word returned by instruction memory.
- fetch_en  in  1  when low, no new read starts; a read already in progress completes.
- redirect_valid  in  1  one-cycle redirect request.
- redirect_pc  in  64  redirect target; bits [1:0] are ignored and forced to 0.
- inst_valid  out  1  queue head valid.
- inst_data  out  32  queue head instruction.
- inst_pc  out  64  address of queue head.
- inst_ready  in  1  consumer accepts the head when inst_valid && inst_ready.

## Operation
- State: fetch PC `pc`, down-counter `cnt` (4 bits), FSM, 2-entry FIFO of {pc, data}, and `count` (0..2).
- imem_addr = pc at all times.
- FSM states:
  - IDLE:
    - If fetch_en, load cnt=WAIT_CYCLES and go to WAIT.
  - WAIT:
    - If cnt>1, cnt-- each cycle.
    - At the edge where cnt==1, sample imem_data. If space is available, push {pc, imem_data} and set pc+=4. Then, if fetch_en, reload cnt=WAIT_CYCLES and stay in WAIT; otherwise go to IDLE.
    - If no space is available, latch the sampled word into a hold register and go to HOLD.
  - HOLD:
    - Wait for space, then push the held word and set pc+=4.
    - Then go to WAIT (reload cnt) if fetch_en, else go to IDLE.
- Space is available when count<2, or when count==2 and a pop occurs in the same cycle.
- A pop occurs when inst_valid && inst_ready. It removes the head.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- Redirect has the highest priority and applies in any state:
  - flush FIFO (count=0) and discard the hold register;
  - set pc=redirect_pc with [1:0] forced to 00;
  - set state=WAIT with cnt=WAIT_CYCLES, regardless of fetch_en;
  - ignore any push or pop in that same cycle.
- pc arithmetic is 64-bit modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- inst_data/inst_pc must not change while inst_valid && !inst_ready.

## Timing
- During Reset: pc=RESET_PC, state=IDLE, count=0, cnt=0, inst_valid=0, inst_data=0, inst_pc=0, imem_addr=RESET_PC.
- A Reset asserted mid-read abandons the read; no push occurs.
- Fetch latency is WAIT_CYCLES cycles of address hold, plus 1 cycle to inst_valid.
  - Example with WAIT_CYCLES=2 and fetch_en=1: reset falls before cycle 0. The address is held for cycles 0–1, the push happens at the end of cycle 1, and inst_valid=1 in cycle 2.
  - IDLE→WAIT costs 1 extra cycle. After reset with fetch_en already high, the first read starts in cycle 1.
- Steady-state throughput is 1 instruction per WAIT_CYCLES cycles while the consumer keeps up.
- Redirect in cycle n: imem_addr=redirect_pc in cycle n+1, inst_valid=0 in cycle n+1, and the first new instruction is valid in cycle n+1+WAIT_CYCLES.
- A word stalled in HOLD is pushed on the edge of the first cycle with a pop, and is visible as head when it reaches the front.
- inst_valid = (count!=0), taken directly from registers with no combinational path from inst_ready.

## Test plan
- Reset then fetch_en=1, inst_ready=1, with the memory model loaded with the test program:
  - the stream shows pc 0x0/F84003E9, 0x4/F84083EA, 0x8/F84103EB, 0xC/F84183EC;
  - with the cycle counting defined in Timing, the first inst_valid occurs at cycle 3 (one IDLE→WAIT cycle, two hold cycles).
- inst_ready=0 for 20 cycles:
  - count reaches 2 and the FSM sits in HOLD with pc=0x8;
  - head stays pc 0x0 throughout;
  - on the first pop, 0x8/F84103EB is pushed in the same cycle and no word is lost or duplicated.
- Redirect to 0x1C while 2 entries are queued and a read of 0x14 is mid-wait:
  - next cycle inst_valid=0 and imem_addr=0x1C;
  - after WAIT_CYCLES cycles the head is 0x1C with the memory's word at 0x1C;
  - the word at 0x14 never appears.
- Redirect to 0x23 in the same cycle as a pop and a push: the queue ends empty and the next head pc is 0x20 (data 8B0901AD).
- fetch_en deasserted during WAIT: the current word (0x10/F84203ED) is delivered, then the FSM goes IDLE, imem_addr holds 0x14 and no further pushes occur until fetch_en returns.
- Reset asserted mid-wait with count=1: the next cycle has inst_valid=0, imem_addr=RESET_PC, and no push from the aborted read.
